// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-pipelined adder/subtractor, one SEG-bit slice per stage
// Each stage adds one slice; higher operand slices ride along in skew regs, finished low slices in the sum reg.

module pipelined_adder #(
    parameter int WIDTH = 10,
    parameter int SEG   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int NST = WIDTH / SEG;

    logic             w_en;
    logic [WIDTH-1:0] w_b_int;
    logic             w_c_int;
    logic             r_ov;

    assign w_b_int = sub ? ~b : b;
    assign w_c_int = sub | ci;

    genvar k;
    for (k = 0; k < NST; k++) begin : g_st
        localparam int RW = WIDTH - k * SEG;
        localparam int SW = (k + 1) * SEG;

        logic [RW-1:0]  w_ain;
        logic [RW-1:0]  w_bin;
        logic           w_cin;
        logic           w_vin;
        logic [SEG:0]   w_sum;
        logic [SW-1:0]  w_snext;
        logic           r_v;
        logic           r_c;
        logic [SW-1:0]  r_s;

        if (k == 0) begin : g_in
            assign w_ain   = a;
            assign w_bin   = w_b_int;
            assign w_cin   = w_c_int;
            assign w_vin   = in_valid;
            assign w_snext = w_sum[SEG-1:0];
        end else begin : g_in
            // Skew registers: the not-yet-added upper slices, aligned so slice 0 is this stage's
            logic [RW-1:0] r_a;
            logic [RW-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en && g_st[k-1].w_vin) begin
                    r_a <= g_st[k-1].w_ain[RW+SEG-1:SEG];
                    r_b <= g_st[k-1].w_bin[RW+SEG-1:SEG];
                end
            end

            assign w_ain   = r_a;
            assign w_bin   = r_b;
            assign w_cin   = g_st[k-1].r_c;
            assign w_vin   = g_st[k-1].r_v;
            assign w_snext = {w_sum[SEG-1:0], g_st[k-1].r_s};
        end

        assign w_sum = {1'b0, w_ain[SEG-1:0]} + {1'b0, w_bin[SEG-1:0]} + {{SEG{1'b0}}, w_cin};

        // Data only loads with a valid beat, so outputs keep the last result while idle
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_vin;
                if (w_vin) begin
                    r_s <= w_snext;
                    r_c <= w_sum[SEG];
                end
            end
        end

        if (k == NST - 1) begin : g_last
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ov <= 1'b0;
                end else if (w_en && w_vin) begin
                    r_ov <= (w_ain[SEG-1] == w_bin[SEG-1]) && (w_sum[SEG-1] != w_ain[SEG-1]);
                end
            end
        end
    end

    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = g_st[NST-1].r_v;
    assign s         = g_st[NST-1].r_s;
    assign co        = g_st[NST-1].r_c;
    assign ov        = r_ov;

endmodule
